// File: rtl/peak_dpu_pkg.sv
// Shared types for the DPU dp issue path: unit ids, reservation entry and MUL latency bounds.
package peak_dpu_pkg;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_ALU  = 2'd1,
        UNIT_MUL  = 2'd2,
        UNIT_DIV  = 2'd3
    } unit_e;

    typedef struct packed {
        logic       vld;
        unit_e      unit;
        logic [4:0] addr;
    } resv_t;

    localparam int unsigned MUL_LAT_MIN = 2;
    localparam int unsigned MUL_LAT_MAX = 8;

endpackage

// File: rtl/peak_dpu_dp_issue_if.sv
// Decoder/execution-unit side of the dp issue scheduler: instruction handshake, unit strobes, write port.
interface peak_dpu_dp_issue_if;

    logic       de_vld;
    logic       de_rdy;
    logic       de_is_alu;
    logic       de_is_mul;
    logic       de_is_div;
    logic       de_rs0_vld;
    logic [4:0] de_rs0_addr;
    logic       de_rs1_vld;
    logic [4:0] de_rs1_addr;
    logic       de_wr_vld;
    logic [4:0] de_wr_addr;
    logic       alu_issue;
    logic       mul_issue;
    logic       div_issue;
    logic       div_done;
    logic       div_ack;
    logic       wb_vld;
    logic [1:0] wb_sel;
    logic [4:0] wb_addr;

    modport master (
        output de_vld, de_is_alu, de_is_mul, de_is_div,
        output de_rs0_vld, de_rs0_addr, de_rs1_vld, de_rs1_addr,
        output de_wr_vld, de_wr_addr, div_done,
        input  de_rdy, alu_issue, mul_issue, div_issue, div_ack,
        input  wb_vld, wb_sel, wb_addr
    );

    modport slave (
        input  de_vld, de_is_alu, de_is_mul, de_is_div,
        input  de_rs0_vld, de_rs0_addr, de_rs1_vld, de_rs1_addr,
        input  de_wr_vld, de_wr_addr, div_done,
        output de_rdy, alu_issue, mul_issue, div_issue, div_ack,
        output wb_vld, wb_sel, wb_addr
    );

endinterface

// File: rtl/peak_dpu_dp_scoreboard.sv
// Outstanding-write scoreboard for x1..x31 with source/destination hazard compare.
// PEAK_DPU_DP_BYPASS_EN: hide the register being written back this cycle from the hazard check.
module peak_dpu_dp_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_vld,
    input  logic [4:0] set_addr,
    input  logic       clr_vld,
    input  logic [4:0] clr_addr,
    input  logic       rs0_vld,
    input  logic [4:0] rs0_addr,
    input  logic       rs1_vld,
    input  logic [4:0] rs1_addr,
    input  logic       wr_vld,
    input  logic [4:0] wr_addr,
    output logic       hazard
);

    logic [31:0] pending_q, pending_d;
    logic [31:0] set_oh, clr_oh, visible;

    always_comb begin
        set_oh = {31'd0, set_vld} << set_addr;
        clr_oh = {31'd0, clr_vld} << clr_addr;
        // Set wins over clear; bit 0 is held clear so x0 never stalls anything.
        pending_d = ((pending_q & ~clr_oh) | set_oh) & ~32'd1;
`ifdef PEAK_DPU_DP_BYPASS_EN
        visible = pending_q & ~clr_oh;
`else
        visible = pending_q;
`endif
        hazard = (rs0_vld & visible[rs0_addr])
               | (rs1_vld & visible[rs1_addr])
               | (wr_vld  & visible[wr_addr]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/peak_dpu_dp_issue.sv
// Issue scheduler for the DPU dp units: reservation pipe, write-port arbitration and DIV tracking.
// PEAK_DPU_DP_BYPASS_EN enables same-cycle writeback bypass inside peak_dpu_dp_scoreboard.
module peak_dpu_dp_issue
    import peak_dpu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input logic                clk,
    input logic                rst_n,
    peak_dpu_dp_issue_if.slave dp
);

    if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_mul_lat
        $error("peak_dpu_dp_issue: MUL_LAT out of range");
    end

    resv_t [MUL_LAT:1] resv_q, resv_d;
    logic              run_q, run_d;
    logic              div_busy_q, div_busy_d;
    logic [4:0]        div_addr_q, div_addr_d;

    logic       wb_vld;
    unit_e      wb_sel;
    logic [4:0] wb_addr;
    logic       div_ack;
    logic       div_wait;
    logic       hazard;
    logic       struct_stall;
    logic       de_rdy;

    always_comb begin
        wb_vld  = 1'b0;
        wb_sel  = UNIT_NONE;
        wb_addr = '0;
        div_ack = 1'b0;
        if (resv_q[1].vld) begin
            wb_vld  = 1'b1;
            wb_sel  = resv_q[1].unit;
            wb_addr = resv_q[1].addr;
        end else if (run_q && dp.div_done) begin
            wb_vld  = 1'b1;
            wb_sel  = UNIT_DIV;
            wb_addr = div_addr_q;
            div_ack = 1'b1;
        end
    end

    // A waiting DIV result blocks ALU/MUL so the pipe drains to it within MUL_LAT cycles.
    assign div_wait     = run_q & dp.div_done & ~div_ack;
    assign struct_stall = (dp.de_is_alu & (resv_q[2].vld | div_wait))
                        | (dp.de_is_mul & div_wait)
                        | (dp.de_is_div & div_busy_q);
    assign de_rdy       = run_q & dp.de_vld & ~hazard & ~struct_stall;

    always_comb begin
        run_d = 1'b1;
        // Shifting the packed pipe right by one entry moves e[k+1] to e[k] and empties the top.
        resv_d = resv_q >> $bits(resv_t);
        if (de_rdy && dp.de_is_alu && dp.de_wr_vld) begin
            resv_d[1] = '{vld: 1'b1, unit: UNIT_ALU, addr: dp.de_wr_addr};
        end
        if (de_rdy && dp.de_is_mul && dp.de_wr_vld) begin
            resv_d[MUL_LAT] = '{vld: 1'b1, unit: UNIT_MUL, addr: dp.de_wr_addr};
        end
        div_busy_d = div_busy_q;
        div_addr_d = div_addr_q;
        if (div_ack) begin
            div_busy_d = 1'b0;
        end
        if (de_rdy && dp.de_is_div) begin
            div_busy_d = 1'b1;
            div_addr_d = dp.de_wr_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_q     <= '0;
            run_q      <= 1'b0;
            div_busy_q <= 1'b0;
            div_addr_q <= '0;
        end else begin
            resv_q     <= resv_d;
            run_q      <= run_d;
            div_busy_q <= div_busy_d;
            div_addr_q <= div_addr_d;
        end
    end

    peak_dpu_dp_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vld  (de_rdy & dp.de_wr_vld),
        .set_addr (dp.de_wr_addr),
        .clr_vld  (wb_vld),
        .clr_addr (wb_addr),
        .rs0_vld  (dp.de_rs0_vld),
        .rs0_addr (dp.de_rs0_addr),
        .rs1_vld  (dp.de_rs1_vld),
        .rs1_addr (dp.de_rs1_addr),
        .wr_vld   (dp.de_wr_vld),
        .wr_addr  (dp.de_wr_addr),
        .hazard   (hazard)
    );

    assign dp.de_rdy    = de_rdy;
    assign dp.alu_issue = de_rdy & dp.de_is_alu;
    assign dp.mul_issue = de_rdy & dp.de_is_mul;
    assign dp.div_issue = de_rdy & dp.de_is_div;
    assign dp.div_ack   = div_ack;
    assign dp.wb_vld    = wb_vld;
    assign dp.wb_sel    = wb_sel;
    assign dp.wb_addr   = wb_addr;

endmodule

// File: tb/tb_peak_dpu_dp_issue.sv
// Bench for peak_dpu_dp_issue: directed scenarios plus randomized traffic against a schedule-based model.
module tb_peak_dpu_dp_issue;
    import peak_dpu_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    logic [12:0] o, e;

    peak_dpu_dp_issue_if dp();

    peak_dpu_dp_issue #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(input logic rdy, input logic ai, input logic mi, input logic di,
                                       input logic ack, input logic wbv, input logic [1:0] sel,
                                       input logic [4:0] a);
        return {rdy, ai, mi, di, ack, wbv, sel, a};
    endfunction

    function automatic logic [12:0] obs();
        return {dp.de_rdy, dp.alu_issue, dp.mul_issue, dp.div_issue, dp.div_ack,
                dp.wb_vld, dp.wb_sel, dp.wb_addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // u: 0 idle, 1 ALU, 2 MUL, 3 DIV
    task automatic drive(input logic [1:0] u, input logic r0v, input logic [4:0] r0,
                         input logic r1v, input logic [4:0] r1, input logic [4:0] wr);
        dp.de_vld      = (u != 2'd0);
        dp.de_is_alu   = (u == 2'd1);
        dp.de_is_mul   = (u == 2'd2);
        dp.de_is_div   = (u == 2'd3);
        dp.de_rs0_vld  = r0v;
        dp.de_rs0_addr = r0;
        dp.de_rs1_vld  = r1v;
        dp.de_rs1_addr = r1;
        dp.de_wr_vld   = (u != 2'd0);
        dp.de_wr_addr  = wr;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dp.div_done = 1'b0;
        drive(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
        repeat (2) tick();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL reset_hold got=%b exp=%b", o, e); end
        tick();
        rst_n = 1'b1;
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL reset_release_cycle got=%b exp=%b", o, e); end
        tick();
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL first_alu_issue got=%b exp=%b", o, e); end
        tick(); idle();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd1,5'd1);
        if (o !== e) begin bad++; $display("FAIL first_alu_wb got=%b exp=%b", o, e); end
        tick();
    endtask

    task automatic test_alu_dep();
        logic byp;
`ifdef PEAK_DPU_DP_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        drive(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL dep_producer got=%b exp=%b", o, e); end
        tick(); drive(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 5'd6);
        mid(); total++; o = obs(); e = pk(byp,byp,0,0,0,1,2'd1,5'd5);
        if (o !== e) begin bad++; $display("FAIL dep_consumer_t1 got=%b exp=%b", o, e); end
        tick();
`ifndef PEAK_DPU_DP_BYPASS_EN
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL dep_consumer_t2 got=%b exp=%b", o, e); end
        tick();
`endif
        idle();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd1,5'd6);
        if (o !== e) begin bad++; $display("FAIL dep_consumer_wb got=%b exp=%b", o, e); end
        tick();
    endtask

    task automatic test_mul_alu_conflict();
        drive(2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd6);
        mid(); total++; o = obs(); e = pk(1,0,1,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL conflict_mul_issue got=%b exp=%b", o, e); end
        tick(); idle();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL conflict_gap got=%b exp=%b", o, e); end
        tick(); drive(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL conflict_alu_stall got=%b exp=%b", o, e); end
        tick();
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,1,2'd2,5'd6);
        if (o !== e) begin bad++; $display("FAIL conflict_alu_issue got=%b exp=%b", o, e); end
        tick(); idle();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd1,5'd7);
        if (o !== e) begin bad++; $display("FAIL conflict_alu_wb got=%b exp=%b", o, e); end
        tick();
    endtask

    task automatic test_div_guard();
        drive(2'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8);
        mid(); total++; o = obs(); e = pk(1,0,0,1,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL div_issue got=%b exp=%b", o, e); end
        tick(); drive(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL div_alu_stream got=%b exp=%b", o, e); end
        tick(); drive(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd2); dp.div_done = 1'b1;
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd1,5'd1);
        if (o !== e) begin bad++; $display("FAIL div_guard_block got=%b exp=%b", o, e); end
        tick(); drive(2'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
        mid(); total++; o = obs(); e = pk(0,0,0,0,1,1,2'd3,5'd8);
        if (o !== e) begin bad++; $display("FAIL div_ack_wb got=%b exp=%b", o, e); end
        tick(); dp.div_done = 1'b0;
        mid(); total++; o = obs(); e = pk(1,0,0,1,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL div_second_issue got=%b exp=%b", o, e); end
        tick(); idle(); dp.div_done = 1'b1;
        mid(); total++; o = obs(); e = pk(0,0,0,0,1,1,2'd3,5'd9);
        if (o !== e) begin bad++; $display("FAIL div_second_wb got=%b exp=%b", o, e); end
        tick(); dp.div_done = 1'b0;
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL div_quiet got=%b exp=%b", o, e); end
        tick();
    endtask

    task automatic test_back_to_back_mul();
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'(9 + i));
            mid(); total++; o = obs(); e = pk(1,0,1,0,0,0,2'd0,5'd0);
            if (o !== e) begin bad++; $display("FAIL b2b_mul_issue%0d got=%b exp=%b", i, o, e); end
            tick();
        end
        drive(2'd1, 1'b1, 5'd10, 1'b0, 5'd0, 5'd12);
        for (int i = 0; i < 2; i++) begin
            mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd2,5'(9 + i));
            if (o !== e) begin bad++; $display("FAIL b2b_mul_wb%0d got=%b exp=%b", i, o, e); end
            tick();
        end
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,1,2'd2,5'd11);
        if (o !== e) begin bad++; $display("FAIL b2b_mul_wb2_dep got=%b exp=%b", o, e); end
        tick(); idle();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd1,5'd12);
        if (o !== e) begin bad++; $display("FAIL b2b_dep_wb got=%b exp=%b", o, e); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd13);
        mid(); total++; o = obs(); e = pk(1,0,1,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL rstmid_mul_issue got=%b exp=%b", o, e); end
        tick(); idle(); rst_n = 1'b0;
        #1; total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL rstmid_immediate got=%b exp=%b", o, e); end
        drive(2'd1, 1'b1, 5'd13, 1'b0, 5'd0, 5'd14);
        tick(); tick();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL rstmid_no_stale got=%b exp=%b", o, e); end
        tick(); rst_n = 1'b1;
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL rstmid_release got=%b exp=%b", o, e); end
        tick();
        mid(); total++; o = obs(); e = pk(1,1,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL rstmid_pending_clear got=%b exp=%b", o, e); end
        tick(); idle();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,1,2'd1,5'd14);
        if (o !== e) begin bad++; $display("FAIL rstmid_wb got=%b exp=%b", o, e); end
        tick();
        mid(); total++; o = obs(); e = pk(0,0,0,0,0,0,2'd0,5'd0);
        if (o !== e) begin bad++; $display("FAIL rstmid_quiet got=%b exp=%b", o, e); end
        tick();
    endtask

    // Model: writebacks kept as an absolute-cycle schedule, pending registers as a set of bits.
    task automatic test_random();
        bit [31:0]  pend;
        int         sched_u[int];
        int         sched_a[int];
        bit         dbusy, cv;
        logic [4:0] daddr, r0, r1, wr;
        int         dcnt;
        logic [1:0] cu;
        logic       r0v, r1v;
        pend = '0; dbusy = 1'b0; cv = 1'b0; daddr = '0; dcnt = 0;
        cu = 2'd0; r0v = 1'b0; r1v = 1'b0; r0 = '0; r1 = '0; wr = '0;
        rst_n = 1'b0; idle(); dp.div_done = 1'b0;
        tick(); rst_n = 1'b1;
        tick(); tick();
        for (int c = 0; c < 600; c++) begin
            bit         ewv, eack, haz, st, dwait, erdy;
            logic [1:0] es;
            logic [4:0] ea;
            bit [31:0]  eff;
            dp.div_done = dbusy && (dcnt == 0);
            if (dbusy && dcnt > 0) dcnt--;
            if (!cv && $urandom_range(0, 9) < 7) begin
                cv  = 1'b1;
                cu  = 2'($urandom_range(1, 3));
                r0v = 1'($urandom_range(0, 1));
                r1v = 1'($urandom_range(0, 1));
                r0  = 5'($urandom_range(0, 7));
                r1  = 5'($urandom_range(0, 7));
                wr  = 5'($urandom_range(0, 7));
            end
            if (cv) drive(cu, r0v, r0, r1v, r1, wr);
            else    idle();
            ewv = 1'b0; eack = 1'b0; es = 2'd0; ea = 5'd0;
            if (sched_u.exists(c)) begin
                ewv = 1'b1; es = 2'(sched_u[c]); ea = 5'(sched_a[c]);
            end else if (dp.div_done) begin
                ewv = 1'b1; eack = 1'b1; es = 2'd3; ea = daddr;
            end
            eff = pend;
`ifdef PEAK_DPU_DP_BYPASS_EN
            if (ewv) eff[ea] = 1'b0;
`endif
            haz   = (r0v && eff[r0]) || (r1v && eff[r1]) || eff[wr];
            dwait = dp.div_done && !eack;
            st    = (cu == 2'd1 && (sched_u.exists(c + 1) || dwait))
                 || (cu == 2'd2 && dwait) || (cu == 2'd3 && dbusy);
            erdy  = cv && !haz && !st;
            mid(); total++; o = obs();
            e = pk(erdy, erdy && cu == 2'd1, erdy && cu == 2'd2, erdy && cu == 2'd3, eack, ewv, es, ea);
            if (o !== e) begin bad++; $display("FAIL random_cycle%0d got=%b exp=%b", c, o, e); end
            if (ewv) pend[ea] = 1'b0;
            if (eack) dbusy = 1'b0;
            if (erdy) begin
                if (wr != 5'd0) pend[wr] = 1'b1;
                case (cu)
                    2'd1: begin sched_u[c + 1] = 1; sched_a[c + 1] = int'(wr); end
                    2'd2: begin sched_u[c + int'(MUL_LAT)] = 2; sched_a[c + int'(MUL_LAT)] = int'(wr); end
                    default: begin dbusy = 1'b1; daddr = wr; dcnt = $urandom_range(0, 4); end
                endcase
                cv = 1'b0;
            end
            if (sched_u.exists(c)) begin sched_u.delete(c); sched_a.delete(c); end
            tick();
        end
        idle(); dp.div_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        dp.div_done = 1'b0;
        idle();
        test_reset();
        test_alu_dep();
        test_mul_alu_conflict();
        test_div_guard();
        test_back_to_back_mul();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peak_dpu_dp_issue.md
# peak_dpu_dp_issue

Issue scheduler for the DPU data-processing units. Sits between the dp instruction decoder and the ALU/MUL/DIV execution units. It holds a decoded instruction until its source/destination registers and its target unit are free, then issues it. It also arbitrates the single register-file write port among the units and tracks outstanding writes in a 31-entry scoreboard.

## Interface
Parameters:
- MUL_LAT, 3, MUL issue-to-writeback latency in cycles (legal range 2..8)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- de_vld  in  1  decoded dp instruction valid
- de_rdy  out  1  instruction accepted (issued) this cycle
- de_is_alu / de_is_mul / de_is_div  in  1 each  target unit, one-hot when de_vld=1
- de_rs0_vld, de_rs0_addr  in  1, 5  source 0
- de_rs1_vld, de_rs1_addr  in  1, 5  source 1
- de_wr_vld, de_wr_addr  in  1, 5  destination
- alu_issue / mul_issue / div_issue  out  1 each  issue strobe to the unit, equal to de_vld & de_rdy & de_is_*
- div_done  in  1  DIV result ready; held high until div_ack
- div_ack  out  1  DIV result takes the write port this cycle
- wb_vld  out  1  register-file write this cycle
- wb_sel  out  2  write-port owner (package unit id)
- wb_addr  out  5  write destination

## Operation
- Reservation pipe: entries e[1..MUL_LAT], each {vld, unit, addr}. e[k] is the writeback k cycles from now. Each cycle: e[k] <= e[k+1] and e[MUL_LAT] <= 0. An issue in the same cycle inserts its entry.
- Write port, combinational: if e[1].vld, then wb_vld=1, wb_sel=e[1].unit, wb_addr=e[1].addr. Otherwise, if div_done=1, then wb_vld=1, wb_sel=DIV, wb_addr=div_addr, div_ack=1. Otherwise wb_vld=0.
- ALU issue books slot 1 (next cycle). It requires that e[2] is empty before the shift.
- MUL issue books slot MUL_LAT. It is always free, because only issue writes the top entry.
- ALU-slot conflict: a MUL issued earlier occupying the next-cycle slot stalls the ALU instruction.
- DIV issue requires that div_busy=0. On issue, set div_busy and latch div_addr. On div_ack, clear div_busy. DIV books no slot.
- DIV starvation guard: while div_done=1 and div_ack=0, de_rdy=0 for ALU and MUL instructions. This guarantees a grant within MUL_LAT cycles.
- Scoreboard pending[31:1], with x0 never pending:
  - On issue with de_wr_vld=1 and addr≠0, set pending[addr].
  - On a wb_vld write, clear pending[wb_addr].
- Hazard stall: any valid source or the destination has its pending bit set. No forwarding.
- Set/clear collision on the same register cannot occur, because issue requires that the destination is not pending.
- de_rdy = de_vld & ~hazard & ~structural_stall. It has no combinational dependency on unit outputs other than div_done.
- Reset mid-operation: all reservations, pending bits, div_busy and div_addr are cleared immediately. In-flight results are dropped, and the execution units are reset alongside.

## Timing
- Reset values: de_rdy=0, all *_issue=0, div_ack=0, wb_vld=0, wb_sel=NONE, wb_addr=0, pending=0, div_busy=0.
- ALU: issue at cycle t, writeback at t+1.
- MUL: issue at t, writeback at t+MUL_LAT.
- DIV: writeback in the first cycle with div_done=1 and e[1] empty.
- Dependent instruction, without bypass: it issues the cycle after the producer's writeback.
- No more than one issue per cycle. No more than one write per cycle.

## Configuration
- PEAK_DPU_DP_BYPASS_EN
- Defined: the hazard check masks the pending bit being cleared by this cycle's writeback. A dependent instruction issues in the writeback cycle, and the execution units receive the result through the write-port forward path.
- Undefined: strict stall as in Operation.

## Structure
- Package peak_dpu_pkg holds:
  - unit ids: NONE=2'd0, ALU=2'd1, MUL=2'd2, DIV=2'd3
  - the reservation entry typedef
  - the MUL_LAT legal bounds
- Sub-module peak_dpu_dp_scoreboard contains the pending vector, set/clear logic and hazard compare, including the bypass mask.

## Test plan
- Reset: hold rst_n=0 with de_vld=1, then release. All outputs stay at reset values until the first edge. The first ALU instruction issues the cycle after release.
- ALU x5 at t0, then ALU reading x5 (MUL_LAT=3): first writes x5 at t1. Second issues at t2 without bypass, or at t1 with PEAK_DPU_DP_BYPASS_EN.
- MUL x6 at t0, then independent ALU x7 presented at t2: ALU stalls at t2 (slot t3 held by MUL) and issues at t3. Writebacks are x6@t3, x7@t4.
- DIV x8 issued, div_done raised while the ALU stream has e[1] booked: new ALU/MUL issues blocked. div_ack and wb x8 occur within ≤3 cycles, and a second DIV stays stalled until div_ack.
- Independent back-to-back MUL x9,x10,x11: issued on consecutive cycles and written on consecutive cycles starting t+3. Pending clears in order.
- rst_n asserted low with MUL pending: pending=0 and wb_vld=0 immediately. After release, no stale writeback appears.
